mem_port_arbiter: RTL

//  Shares one memory_controller port between instruction fetch (stage_1) and the data/load-store stage.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/arb_prio_sel.sv | 53 +++++
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM states, operation
// codes, requester select codes and the fetch wait-counter width.
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_ACCESS = 1'b1
    } arb_state_e;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam logic SRC_I = 1'b0;
    localparam logic SRC_D = 1'b1;

    localparam int WAIT_W = 4;
    localparam logic [WAIT_W-1:0] WAIT_SAT = 4'd15;

    // Saturating increment for the fetch starvation counter.
    function automatic logic [WAIT_W-1:0] wait_sat_inc(input logic [WAIT_W-1:0] v);
        logic [WAIT_W-1:0] r;
        if (v == WAIT_SAT) begin
            r = v;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/arb_prio_sel.sv
// Winner selection for the memory port: data wins by default, fetch wins
// once it has lost MAX_WAIT consecutive contended grants. Also owns the
// saturating wait counter.
module arb_prio_sel
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic              d_req,
    input  logic              accept_en,
    output logic              sel,
    output logic              i_gnt,
    output logic              d_gnt,
    output logic [WAIT_W-1:0] wait_cnt
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt_r;
    logic              fetch_win_s;

    // Pick the winner and derive the mutually exclusive grants.
    always_comb begin
        fetch_win_s = 1'b0;
        if (i_req && (!d_req || (wait_cnt_r >= MAX_WAIT_C))) begin
            fetch_win_s = 1'b1;
        end else begin
            fetch_win_s = 1'b0;
        end
        sel   = fetch_win_s ? SRC_I : SRC_D;
        i_gnt = accept_en && fetch_win_s;
        d_gnt = accept_en && d_req && !fetch_win_s;
    end

    // Count data grants that fetch lost; any fetch grant clears the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (i_gnt) begin
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else if (d_gnt && i_req) begin
            wait_cnt_r <= wait_sat_inc(wait_cnt_r);
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    assign wait_cnt = wait_cnt_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory controller port between instruction fetch and the
// load/store stage. One access per cycle: grant -> ACCESS -> rvalid.
// Optional statistics counters are enabled with MEM_ARB_STATS_EN.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_i_val,
    output logic          mem_op_type,
    input  logic [DW-1:0] mem_o_val
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [31:0]   stat_i_cnt,
    output logic [31:0]   stat_d_cnt,
    output logic [31:0]   stat_conflict_cnt
`endif
);

    arb_state_e        state_r;
    logic              src_r;
    logic              sel_s;
    logic              accept_en_s;
    logic              accept_s;
    logic [WAIT_W-1:0] wait_cnt_s;

    // Requests are accepted in both states, giving back-to-back throughput.
    assign accept_en_s = (state_r == ARB_IDLE) || (state_r == ARB_ACCESS);
    assign accept_s    = i_gnt || d_gnt;

    arb_prio_sel #(
        .MAX_WAIT (MAX_WAIT)
    ) u_sel (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .d_req     (d_req),
        .accept_en (accept_en_s),
        .sel       (sel_s),
        .i_gnt     (i_gnt),
        .d_gnt     (d_gnt),
        .wait_cnt  (wait_cnt_s)
    );

    // FSM plus access registers; mem_op_type only pulses for one ACCESS cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ARB_IDLE;
            src_r       <= SRC_I;
            mem_address <= {AW{1'b0}};
            mem_i_val   <= {DW{1'b0}};
            mem_op_type <= OP_READ;
        end else begin
            case (state_r)
                ARB_IDLE:   state_r <= accept_s ? ARB_ACCESS : ARB_IDLE;
                ARB_ACCESS: state_r <= accept_s ? ARB_ACCESS : ARB_IDLE;
                default:    state_r <= ARB_IDLE;
            endcase
            if (accept_s) begin
                src_r <= sel_s;
                if (sel_s == SRC_I) begin
                    mem_address <= i_addr;
                    mem_op_type <= OP_READ;
                end else begin
                    mem_address <= d_addr;
                    mem_i_val   <= d_wdata;
                    mem_op_type <= d_we ? OP_WRITE : OP_READ;
                end
            end else begin
                mem_op_type <= OP_READ;
            end
        end
    end

    // Capture the port read data for whichever requester owned the ACCESS cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_rdata  <= {DW{1'b0}};
            d_rdata  <= {DW{1'b0}};
        end else begin
            if ((state_r == ARB_ACCESS) && (src_r == SRC_I)) begin
                i_rvalid <= 1'b1;
                i_rdata  <= mem_o_val;
            end else begin
                i_rvalid <= 1'b0;
            end
            if ((state_r == ARB_ACCESS) && (src_r == SRC_D)) begin
                d_rvalid <= 1'b1;
                d_rdata  <= mem_o_val;
            end else begin
                d_rvalid <= 1'b0;
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    // Free-running grant and contention counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_i_cnt        <= 32'd0;
            stat_d_cnt        <= 32'd0;
            stat_conflict_cnt <= 32'd0;
        end else begin
            stat_i_cnt        <= i_gnt ? (stat_i_cnt + 32'd1) : stat_i_cnt;
            stat_d_cnt        <= d_gnt ? (stat_d_cnt + 32'd1) : stat_d_cnt;
            stat_conflict_cnt <= (i_req && d_req) ? (stat_conflict_cnt + 32'd1) : stat_conflict_cnt;
        end
    end
`endif

endmodule
